piscaleds_n: RTL and testbench

PISCALEDS_N -- requirements
Module: piscaleds_n

---
 rtl/piscaleds_n.sv | 80 ++++++++
 tb/tb_piscaleds_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/piscaleds_n.sv
// piscaleds_n: per-channel LED blinker with debounced speed key, blink and burst modes
module piscaleds_n #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 27,
  parameter int PERIOD       = 50000000,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 5,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BURST_N      = 3
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_CH-1:0]   KEY,
  input  logic [2*N_CH-1:0] MODE,
  output logic [N_CH-1:0]   LEDG,
  output logic [N_CH-1:0]   TICK
);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int BC_W = $clog2(2 * BURST_N + 1);
  localparam logic [CNT_W:0] P      = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0] S_SLOW = (CNT_W+1)'(STEP_SLOW);
  localparam logic [CNT_W:0] S_FAST = (CNT_W+1)'(STEP_FAST);
  if (!(N_CH >= 1 && N_CH <= 16 && STEP_SLOW >= 1 && STEP_SLOW <= STEP_FAST &&
        STEP_FAST <= PERIOD && longint'(PERIOD) < (64'd1 << CNT_W) &&
        DEBOUNCE_CYC >= 1 && BURST_N >= 1)) begin : g_bad
    $error("piscaleds_n: illegal parameter combination");
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       sync;
    logic             db;
    logic [DB_W-1:0]  dcnt;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt;
    logic [BC_W-1:0]  bcnt;
    logic             led;
    logic             tick;
    logic [1:0]       mode;
    logic [CNT_W:0]   nxt;
    logic             chg;
    logic             done;
    logic             run;
    logic             hit;
    logic             mis;
    assign mode = MODE[2*i +: 2];
    assign chg  = mode != mode_q;
    assign done = mode == 2'b11 && bcnt == BC_W'(2 * BURST_N) && !chg;
    assign run  = mode[1] && !done;
    assign nxt  = (chg ? '0 : {1'b0, cnt}) + (db ? S_SLOW : S_FAST);
    assign hit  = nxt >= P;
    assign mis  = sync[1] != db;
    assign LEDG[i] = led;
    assign TICK[i] = tick;
    // Key synchroniser and debouncer: level flips only after DEBOUNCE_CYC consecutive mismatches
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
        sync <= 2'b11;
        db   <= 1'b1;
        dcnt <= '0;
      end else begin
        sync <= {sync[0], KEY[i]};
        dcnt <= (mis && dcnt != DB_W'(DEBOUNCE_CYC - 1)) ? dcnt + 1'b1 : '0;
        if (mis && dcnt == DB_W'(DEBOUNCE_CYC - 1)) db <= sync[1];
      end
    // Phase counter, LED toggle and burst bookkeeping; a mode change restarts from zero with LED off
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
        mode_q <= 2'b00;
        cnt    <= '0;
        bcnt   <= '0;
        led    <= 1'b0;
        tick   <= 1'b0;
      end else begin
        mode_q <= mode;
        cnt    <= (run && !hit) ? nxt[CNT_W-1:0] : '0;
        bcnt   <= (chg ? '0 : bcnt) + BC_W'(mode == 2'b11 && run && hit);
        led    <= mode == 2'b01 ? 1'b1 : run ? ((chg ? 1'b0 : led) ^ hit) : 1'b0;
        tick   <= run && hit;
      end
  end
endmodule

// File: tb/tb_piscaleds_n.sv
// tb_piscaleds_n: directed vectors, corner sequences and randomized run against a behavioural model
module tb_piscaleds_n;
  localparam int NC = 2;
  localparam int PER = 10;
  localparam int SS = 1;
  localparam int SF = 5;
  localparam int DB = 4;
  localparam int BN = 2;
  logic CLOCK_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic [NC-1:0] KEY = '1;
  logic [2*NC-1:0] MODE = '0;
  logic [NC-1:0] LEDG, TICK;
  int checks = 0;
  int failures = 0;
  piscaleds_n #(.N_CH(NC), .CNT_W(8), .PERIOD(PER), .STEP_SLOW(SS), .STEP_FAST(SF),
                .DEBOUNCE_CYC(DB), .BURST_N(BN)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY), .MODE(MODE), .LEDG(LEDG), .TICK(TICK));
  always #5 CLOCK_50 = ~CLOCK_50;
  // Behavioural model: key history, stability run length, phase accumulator, toggle count
  int kh0[NC], kh1[NC], mdb[NC], mstab[NC], mph[NC], mprev[NC], mtog[NC];
  logic [NC-1:0] mled, mtick;
  always @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      for (int c = 0; c < NC; c++) begin
        kh0[c] = 1; kh1[c] = 1; mdb[c] = 1; mstab[c] = 0;
        mph[c] = 0; mprev[c] = 0; mtog[c] = 0;
      end
      mled = '0; mtick = '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        int smp, stp, m;
        stp = (mdb[c] == 0) ? SF : SS;
        smp = kh1[c];
        kh1[c] = kh0[c];
        kh0[c] = KEY[c];
        if (smp != mdb[c]) begin
          mstab[c]++;
          if (mstab[c] == DB) begin mdb[c] = smp; mstab[c] = 0; end
        end else mstab[c] = 0;
        m = int'(MODE[2*c +: 2]);
        if (m != mprev[c]) begin
          mph[c] = 0; mtog[c] = 0;
          if (m >= 2) mled[c] = 1'b0;
        end
        mprev[c] = m;
        mtick[c] = 1'b0;
        if (m == 0) begin mled[c] = 1'b0; mph[c] = 0; end
        else if (m == 1) begin mled[c] = 1'b1; mph[c] = 0; end
        else if (m == 3 && mtog[c] == 2 * BN) begin mled[c] = 1'b0; mph[c] = 0; end
        else begin
          mph[c] += stp;
          if (mph[c] >= PER) begin
            mph[c] = 0; mled[c] = ~mled[c]; mtick[c] = 1'b1; mtog[c]++;
          end
        end
      end
    end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick_n(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask
  task automatic do_reset(input logic [2*NC-1:0] m, input logic [NC-1:0] k);
    RESET_N = 1'b0;
    MODE = m;
    KEY = k;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask
  typedef struct {
    logic [3:0] mode;
    logic [1:0] key;
    int n;
    logic [1:0] led;
    logic [1:0] tick;
  } vec_t;
  vec_t tbl[14];
  initial begin
    int cnt1;
    int c;
    tbl[0]  = '{4'b0010, 2'b11, 0,  2'b00, 2'b00};
    tbl[1]  = '{4'b0010, 2'b11, 9,  2'b00, 2'b00};
    tbl[2]  = '{4'b0010, 2'b11, 10, 2'b01, 2'b01};
    tbl[3]  = '{4'b0010, 2'b11, 11, 2'b01, 2'b00};
    tbl[4]  = '{4'b0010, 2'b11, 20, 2'b00, 2'b01};
    tbl[5]  = '{4'b1000, 2'b01, 6,  2'b00, 2'b00};
    tbl[6]  = '{4'b1000, 2'b01, 7,  2'b10, 2'b10};
    tbl[7]  = '{4'b1000, 2'b01, 9,  2'b00, 2'b10};
    tbl[8]  = '{4'b0001, 2'b11, 1,  2'b01, 2'b00};
    tbl[9]  = '{4'b1100, 2'b11, 10, 2'b10, 2'b10};
    tbl[10] = '{4'b1100, 2'b11, 40, 2'b00, 2'b10};
    tbl[11] = '{4'b1100, 2'b11, 50, 2'b00, 2'b00};
    tbl[12] = '{4'b1110, 2'b11, 10, 2'b11, 2'b11};
    tbl[13] = '{4'b0101, 2'b11, 3,  2'b11, 2'b00};
    for (int v = 0; v < 14; v++) begin
      do_reset(tbl[v].mode, tbl[v].key);
      tick_n(tbl[v].n);
      chk($sformatf("vec%0d_led", v), int'(LEDG), int'(tbl[v].led));
      chk($sformatf("vec%0d_tick", v), int'(TICK), int'(tbl[v].tick));
    end
    // Burst: four toggles, long quiet hold, then re-arm via mode 00
    do_reset(4'b1100, 2'b11);
    for (int t = 1; t <= 140; t++) begin
      @(negedge CLOCK_50);
      chk("burst_tick", int'(TICK[1]), int'(t % 10 == 0 && t <= 40));
      chk("burst_led", int'(LEDG[1]), int'((t >= 10 && t < 20) || (t >= 30 && t < 40)));
    end
    MODE = 4'b0000;
    tick_n(1);
    MODE = 4'b1100;
    for (int t = 1; t <= 45; t++) begin
      @(negedge CLOCK_50);
      chk("rearm_tick", int'(TICK[1]), int'(t % 10 == 0 && t <= 40));
    end
    // Mode switch mid-count
    do_reset(4'b0010, 2'b11);
    tick_n(6);
    MODE = 4'b0001;
    tick_n(1);
    chk("sw_on_led", int'(LEDG[0]), 1);
    chk("sw_on_tick", int'(TICK[0]), 0);
    MODE = 4'b0010;
    tick_n(1);
    chk("sw_back_led", int'(LEDG[0]), 0);
    tick_n(8);
    chk("sw_t9_led", int'(LEDG[0]), 0);
    chk("sw_t9_tick", int'(TICK[0]), 0);
    tick_n(1);
    chk("sw_t10_led", int'(LEDG[0]), 1);
    chk("sw_t10_tick", int'(TICK[0]), 1);
    // Asynchronous reset between edges during fast blink
    do_reset(4'b0010, 2'b10);
    tick_n(7);
    chk("fast_pre_led", int'(LEDG), 1);
    chk("fast_pre_tick", int'(TICK), 1);
    #2 RESET_N = 1'b0;
    KEY = 2'b11;
    #1;
    chk("async_led", int'(LEDG), 0);
    chk("async_tick", int'(TICK), 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    tick_n(9);
    chk("post_rst_t9", int'(LEDG[0]), 0);
    tick_n(1);
    chk("post_rst_t10_led", int'(LEDG[0]), 1);
    chk("post_rst_t10_tick", int'(TICK), 1);
    // Short key glitch must not change the rate
    do_reset(4'b0010, 2'b11);
    for (int t = 1; t <= 20; t++) begin
      KEY[0] = (t >= 3 && t <= 5) ? 1'b0 : 1'b1;
      @(negedge CLOCK_50);
      chk("glitch_tick", int'(TICK[0]), int'(t % 10 == 0));
    end
    // Channel independence
    do_reset(4'b1001, 2'b01);
    cnt1 = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge CLOCK_50);
      chk("indep_led0", int'(LEDG[0]), 1);
      chk("indep_tick0", int'(TICK[0]), 0);
      if (TICK[1]) cnt1++;
    end
    chk("indep_ticks1", cnt1, 7);
    // Randomized run against the model
    do_reset(4'b0000, 2'b11);
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(0, NC - 1);
        KEY[c] = ~KEY[c];
      end
      if ($urandom_range(0, 39) == 0) begin
        c = $urandom_range(0, NC - 1);
        MODE[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      RESET_N = ($urandom_range(0, 299) != 0);
      @(negedge CLOCK_50);
      chk("rand_led", int'(LEDG), int'(mled));
      chk("rand_tick", int'(TICK), int'(mtick));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
